// File: rtl/fpu_div_arbiter.sv
// fpu_div_arbiter: round-robin arbiter sharing one multi-cycle FP divider among NREQ requesters
// Optional feature: define FPU_ARB_TIMEOUT_EN to bound WAIT to DIV_TIMEOUT cycles (abort + NaN result)
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid, req_ready              per-requester handshake; ready is one-hot, only in IDLE
//   req_fpa, req_fpb, req_db, req_rm  per-requester operands, requester i at slice i
//   div_start, div_abort              one-cycle pulses to the divider
//   div_fpa, div_fpb, div_db, div_rm  operands latched at grant, held until the next grant
//   div_done, div_result, div_ieee    divider completion pulse and result
//   rsp_valid, rsp_ready              response handshake; rsp_* held until accepted
//   rsp_id, rsp_result, rsp_ieee      tagged response
//   rsp_timeout                       response produced by a timeout abort
module fpu_div_arbiter #(
    parameter int NREQ        = 2,
    parameter int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [64*NREQ-1:0] req_fpa,
    input  logic [64*NREQ-1:0] req_fpb,
    input  logic [NREQ-1:0]   req_db,
    input  logic [2*NREQ-1:0] req_rm,
    output logic              div_start,
    output logic [63:0]       div_fpa,
    output logic [63:0]       div_fpb,
    output logic              div_db,
    output logic [1:0]        div_rm,
    output logic              div_abort,
    input  logic              div_done,
    input  logic [63:0]       div_result,
    input  logic [4:0]        div_ieee,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [63:0]       rsp_result,
    output logic [4:0]        rsp_ieee,
    output logic              rsp_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [IDW-1:0] rr, grant;
    logic found, expire;
    logic [63:0] sel_fpa, sel_fpb;
    logic sel_db;
    logic [1:0] sel_rm;

    // search upward from the rr pointer, wrapping, and pick that requester's operands
    always_comb begin
        int idx;
        idx = 0;
        found = 1'b0;
        grant = '0;
        sel_fpa = '0;
        sel_fpb = '0;
        sel_db = 1'b0;
        sel_rm = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            idx = (idx >= NREQ) ? idx - NREQ : idx;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
                sel_fpa = req_fpa[64*idx +: 64];
                sel_fpb = req_fpb[64*idx +: 64];
                sel_db = req_db[idx];
                sel_rm = req_rm[2*idx +: 2];
            end
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(DIV_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clk)
        wait_cnt <= (!rst_n || state != WAIT) ? '0 : wait_cnt + 1'b1;
    // a done arriving in the expiry cycle wins over the abort
    assign expire = state == WAIT && !div_done && wait_cnt == CW'(DIV_TIMEOUT - 1);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = found ? ISSUE : IDLE;
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = (div_done || expire) ? RESP : WAIT;
            RESP:  state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so nothing is offered while a reset is pending
    always_comb begin
        req_ready = (rst_n && state == IDLE && found) ? NREQ'(1) << grant : '0;
        div_start = state == ISSUE;
        rsp_valid = state == RESP;
        div_abort = expire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= '0;
            rsp_id <= '0;
            div_fpa <= '0;
            div_fpb <= '0;
            div_db <= 1'b0;
            div_rm <= '0;
            rsp_result <= '0;
            rsp_ieee <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                rr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                rsp_id <= grant;
                div_fpa <= sel_fpa;
                div_fpb <= sel_fpb;
                div_db <= sel_db;
                div_rm <= sel_rm;
            end
            if (state == WAIT && (div_done || expire)) begin
                rsp_result <= div_done ? div_result : 64'h7FF8_0000_0000_0000;
                rsp_ieee <= div_done ? div_ieee : 5'd0;
                rsp_timeout <= expire;
            end
        end
    end
endmodule

// File: tb/tb_fpu_div_arbiter.sv
// tb_fpu_div_arbiter: scoreboard bench for fpu_div_arbiter with a 12-cycle divider model
module tb_fpu_div_arbiter;
    localparam int NREQ = 3;
    localparam int IDW = 2;
`ifdef FPU_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [NREQ-1:0] req_valid, req_ready, req_db;
    logic [64*NREQ-1:0] req_fpa, req_fpb;
    logic [2*NREQ-1:0] req_rm;
    logic div_start, div_db, div_abort, rsp_valid, rsp_ready, rsp_timeout;
    logic [63:0] div_fpa, div_fpb, rsp_result;
    logic [1:0] div_rm;
    logic div_done = 1'b0;
    logic [63:0] div_result = '0;
    logic [4:0] div_ieee = '0, rsp_ieee;
    logic [IDW-1:0] rsp_id;

    fpu_div_arbiter #(.NREQ(NREQ), .IDW(IDW), .DIV_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_fpa(req_fpa), .req_fpb(req_fpb), .req_db(req_db), .req_rm(req_rm),
        .div_start(div_start), .div_fpa(div_fpa), .div_fpb(div_fpb), .div_db(div_db),
        .div_rm(div_rm), .div_abort(div_abort), .div_done(div_done), .div_result(div_result),
        .div_ieee(div_ieee), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_ieee(rsp_ieee), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        logic [63:0] res;
        logic [4:0] ieee;
        logic to;
        int rcyc;
    } exp_t;

    exp_t q[$];
    int idlog[$];
    int checks = 0, errors = 0;
    int cyc = 0, done_cyc = -1, inj_cyc = -1, start_cyc = -1, abort_cyc = -1;
    int ptr = 0, g, rsp_cnt = 0;
    int div_mode = 0;
    bit busy = 0, rsp_active = 0, post_rst = 0;
    logic [63:0] cur_a, cur_b, hold_res, last_res;
    logic cur_db, last_to;
    logic [1:0] cur_rm;
    logic [7:0] hold_tag;
    exp_t e;

    function automatic logic [63:0] fdiv(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) / $bitstoreal(b));
    endfunction

    function automatic logic [4:0] fflags(input logic [63:0] a, input logic [63:0] b,
                                          input logic db, input logic [1:0] rm);
        return {db, rm, a[0] ^ b[0], b[1]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // divider model: done 11 cycles after the start cycle, plus optional injected stray pulses
    always @(posedge clk) begin
        cyc++;
        #1;
        div_done = (cyc == done_cyc) || (cyc == inj_cyc);
        div_result = (cyc == done_cyc) ? fdiv(div_fpa, div_fpb) : 64'hDEAD_BEEF_0BAD_F00D;
        div_ieee = (cyc == done_cyc) ? fflags(div_fpa, div_fpb, div_db, div_rm) : 5'h1F;
    end

    // monitor and reference model: round-robin over pending requesters, one op in flight
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            busy = 0;
            ptr = 0;
            q.delete();
            rsp_active = 0;
            start_cyc = -1;
            abort_cyc = -1;
            done_cyc = -1;
            post_rst = 1;
        end else begin
            if (post_rst) begin
                chk("reset_ops", div_fpa | div_fpb | rsp_result, 64'd0);
                chk("reset_ctl", 64'({div_start, div_abort, rsp_valid, rsp_timeout, div_db,
                                      div_rm, rsp_ieee, rsp_id}), 64'd0);
                post_rst = 0;
            end
            chk("div_start", 64'(div_start), 64'(cyc == start_cyc));
            chk("div_abort", 64'(div_abort), 64'(cyc == abort_cyc));
            if (div_start && cyc == start_cyc) begin
                chk("div_fpa", div_fpa, cur_a);
                chk("div_fpb", div_fpb, cur_b);
                chk("div_db_rm", 64'({div_db, div_rm}), 64'({cur_db, cur_rm}));
                if (div_mode == 0) done_cyc = cyc + 11;
            end
            if (rsp_valid) begin
                if (!rsp_active) begin
                    rsp_cnt++;
                    last_res = rsp_result;
                    last_to = rsp_timeout;
                    idlog.push_back(int'(rsp_id));
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got id %0d result %h expected no response",
                                 rsp_id, rsp_result);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_ieee", 64'(rsp_ieee), 64'(e.ieee));
                        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                        chk("rsp_cycle", 64'(cyc), 64'(e.rcyc));
                    end
                    hold_res = rsp_result;
                    hold_tag = {rsp_timeout, rsp_ieee, rsp_id};
                    rsp_active = 1;
                end else begin
                    chk("rsp_stable_result", rsp_result, hold_res);
                    chk("rsp_stable_tag", 64'({rsp_timeout, rsp_ieee, rsp_id}), 64'(hold_tag));
                end
            end else if (rsp_active) begin
                checks++;
                errors++;
                $display("FAIL rsp_dropped: got rsp_valid 0 expected 1 before handshake");
                rsp_active = 0;
            end
            if (busy) chk("ready_busy", 64'(req_ready), 64'd0);
            else if (req_valid != 0) begin
                g = -1;
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
                chk("grant", 64'(req_ready), 64'd1 << g);
                cur_a = req_fpa[64*g +: 64];
                cur_b = req_fpb[64*g +: 64];
                cur_db = req_db[g];
                cur_rm = req_rm[2*g +: 2];
                e.id = g;
                e.res = (div_mode == 0) ? fdiv(cur_a, cur_b) : 64'h7FF8_0000_0000_0000;
                e.ieee = (div_mode == 0) ? fflags(cur_a, cur_b, cur_db, cur_rm) : 5'd0;
                e.to = div_mode != 0;
                e.rcyc = (div_mode == 0) ? cyc + 13 : (TO_EN ? cyc + 18 : -1);
                q.push_back(e);
                ptr = (g + 1) % NREQ;
                busy = 1;
                start_cyc = cyc + 1;
                abort_cyc = (TO_EN && div_mode != 0) ? cyc + 17 : -1;
            end else chk("ready_idle", 64'(req_ready), 64'd0);
            if (rsp_valid && rsp_ready) begin
                busy = 0;
                rsp_active = 0;
            end
        end
    end

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic load(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic db, input logic [1:0] rm);
        req_fpa[64*i +: 64] = a;
        req_fpb[64*i +: 64] = b;
        req_db[i] = db;
        req_rm[2*i +: 2] = rm;
        req_valid[i] = 1'b1;
    endtask

    function automatic logic [63:0] rnd_op();
        return {1'b0, 11'(1000 + $urandom_range(0, 47)), 32'($urandom), 20'($urandom)};
    endfunction

    task automatic rnd_load(input int i);
        load(i, rnd_op(), rnd_op(), 1'($urandom), 2'($urandom));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || req_valid != 0) && n < 400) begin
            step();
            n++;
        end
        chk("idle_reached", 64'(n < 400), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, n;
        rst_n = 1'b0;
        req_valid = '0;
        req_fpa = '0;
        req_fpb = '0;
        req_db = '0;
        req_rm = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single divide with exact latency
        load(0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 2'd0);
        wait_idle();
        chk("t1_result", last_res, 64'h4008_0000_0000_0000);

        // round robin: 0, 1, then 0 again
        do_reset();
        idlog.delete();
        load(0, rnd_op(), rnd_op(), 1'b1, 2'd1);
        load(1, rnd_op(), rnd_op(), 1'b0, 2'd2);
        wait_idle();
        load(0, rnd_op(), rnd_op(), 1'b1, 2'd3);
        load(1, rnd_op(), rnd_op(), 1'b1, 2'd0);
        wait_idle();
        chk("t2_count", 64'(idlog.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t2_order", 64'(idlog[i]), 64'(i % 2));

        // response back-pressure with another request pending
        rsp_ready = 1'b0;
        rnd_load(2);
        n = 0;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        rnd_load(0);
        repeat (5) step();
        chk("t3_held", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        wait_idle();

        // reset during WAIT, then a late stray done
        rnd_load(1);
        repeat (5) step();
        c0 = rsp_cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        inj_cyc = cyc + 3;
        repeat (20) step();
        chk("t4_no_rsp", 64'(rsp_cnt - c0), 64'd0);

        // divider never completes
        div_mode = 1;
        c0 = rsp_cnt;
        rnd_load(0);
`ifdef FPU_ARB_TIMEOUT_EN
        wait_idle();
        chk("t5_timeout_flag", 64'(last_to), 64'd1);
        chk("t5_timeout_result", last_res, 64'h7FF8_0000_0000_0000);
`else
        repeat (60) step();
        chk("t5_no_rsp", 64'(rsp_cnt - c0), 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        do_reset();
`endif
        div_mode = 0;

        // stray done during ISSUE is ignored
        rnd_load(2);
        inj_cyc = cyc + 1;
        wait_idle();

        // random traffic
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) rnd_load(i);
                else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = $urandom_range(0, 2) != 0;
            step();
        end
        rsp_ready = 1'b1;
        wait_idle();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
